btb: RTL and testbench
======================

BTB -- requirements
Module: btb

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped entries; power of two, range 4..64.
REQ-002 Parameter IDX_W, default 4, index width; equals log2(ENTRIES).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low (0 = reset), deasserted synchronously by the environment.
REQ-005 pc  input  32  fetch-stage PC being looked up this cycle.
REQ-006 update_en  input  1  EX stage resolved a branch or jump this cycle.
REQ-007 update_pc  input  32  PC of the resolved instruction.
REQ-008 update_target  input  32  resolved target address.
REQ-009 update_taken  input  1  resolved direction, 1 = taken.
REQ-010 clear  input  1  synchronous invalidate-all, e.g. on fence.i.
REQ-011 btb_target_pc  output  32  predicted target for pc.
REQ-012 btb_pc_valid  output  1  pc hits a valid entry.
REQ-013 btb_pc_predictTaken  output  1  hit entry predicts taken.

Function
REQ-014 Each entry SHALL hold a valid bit, a tag of pc[31:IDX_W+2], a 32-bit target and a 2-bit saturating counter.
REQ-015 Index SHALL be pc[IDX_W+1:2]; pc[1:0] SHALL be ignored.
REQ-016 Lookup SHALL be combinational from pc, with zero-cycle latency, so fetch uses the result in the same cycle.
REQ-017 btb_pc_valid SHALL be 1 iff the indexed entry is valid and its tag equals the pc tag.
REQ-018 btb_pc_predictTaken SHALL be counter[1] when btb_pc_valid=1, else 0.
REQ-019 btb_target_pc SHALL be the entry target when btb_pc_valid=1, else 0.
REQ-020 Counter encoding SHALL be: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
REQ-021 Update on a hit (update_en=1, entry valid, tag match) SHALL work as follows:
- counter increments, saturating at 11, when update_taken=1; decrements, saturating at 00, when update_taken=0;
- target is overwritten with update_target only when update_taken=1.
REQ-022 Update on a miss with update_taken=1 SHALL allocate the entry: valid=1, tag and target written, counter=10; any previous occupant is replaced.
REQ-023 Update on a miss with update_taken=0 SHALL leave the table unchanged.
REQ-024 A lookup and an update to the same index in the same cycle SHALL return pre-update contents; there is no write-to-read bypass, and the new state is visible from the next cycle.
REQ-025 clear=1 SHALL zero all valid bits at the next edge and SHALL take priority over a simultaneous update_en.
REQ-026 Targets and counters SHALL NOT require reset; only valid bits are reset.

Reset
REQ-027 While rst=0, all valid bits SHALL be 0 immediately, independent of clk, so all three outputs read 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries; the first update after release behaves as a miss.

Verification
REQ-029 After reset, pc=0x00000040 -> btb_pc_valid=0, btb_pc_predictTaken=0, btb_target_pc=0.
REQ-030 Allocate then hit:
- stimulus: update_en=1, update_pc=0x40, update_target=0x100, taken=1; next cycle pc=0x40;
- response: valid=1, predictTaken=1, target=0x100.
REQ-031 Saturating counter:
- stimulus: three taken updates, then two not-taken updates to 0x40;
- response: counter goes 10->11->11->10->01; predictTaken=0 after the final update; target stays 0x100.
REQ-032 Alias:
- stimulus: after REQ-030, update pc=0x80 (same index at ENTRIES=16) taken, target=0x200;
- response: pc=0x40 misses; pc=0x80 hits with target 0x200.
REQ-033 Same-cycle hazard:
- stimulus: pc=0x40 and an update to 0x40 with taken=0 in the same cycle, from counter 10;
- response: predictTaken=1 that cycle and 0 the next.
REQ-034 Clear priority:
- stimulus: clear=1 with a simultaneous taken update to 0xC0;
- response: next cycle pc=0xC0 and pc=0x40 both show valid=0.

Source files
------------

// File: rtl/btb_if.sv
// Branch target buffer port bundle: fetch-side lookup plus EX-side update and invalidate.
// The master drives the lookup and update requests; the slave (the BTB) returns the prediction.
interface btb_if;
  logic [31:0] pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        clear;
  logic [31:0] btb_target_pc;
  logic        btb_pc_valid;
  logic        btb_pc_predictTaken;

  modport master (
    output pc, update_en, update_pc, update_target, update_taken, clear,
    input  btb_target_pc, btb_pc_valid, btb_pc_predictTaken
  );

  modport slave (
    input  pc, update_en, update_pc, update_target, update_taken, clear,
    output btb_target_pc, btb_pc_valid, btb_pc_predictTaken
  );
endinterface

// File: rtl/btb.sv
// Direct-mapped BTB with 2-bit counters; lookup is combinational (0 cycles), updates land at the next edge.
// No backpressure: one lookup and one update are accepted every cycle, and clear wins over update.
module btb #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input logic  clk,
  input logic  rst,
  btb_if.slave bus
);
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  // Only the valid bits carry reset; payload is qualified by them everywhere.
  logic [ENTRIES-1:0] valid;
  entry_t             entries_q [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  entry_t           rd_ent;
  logic             rd_hit;

  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  entry_t           wr_cur;
  logic             wr_hit;
  entry_t           wr_ent;
  logic             wr_en;
  logic             alloc;

  logic unused_lsbs;
  assign unused_lsbs = ^{bus.pc[1:0], bus.update_pc[1:0]};

  assign rd_idx = bus.pc[IDX_W+1:2];
  assign rd_tag = bus.pc[31:IDX_W+2];
  assign rd_ent = entries_q[rd_idx];
  assign rd_hit = valid[rd_idx] && (rd_ent.tag == rd_tag);

  // Reads see the registered table only, so a same-cycle update is not bypassed.
  assign bus.btb_pc_valid        = rd_hit;
  assign bus.btb_pc_predictTaken = rd_hit && rd_ent.ctr[1];
  assign bus.btb_target_pc       = rd_hit ? rd_ent.target : 32'h0;

  assign wr_idx = bus.update_pc[IDX_W+1:2];
  assign wr_tag = bus.update_pc[31:IDX_W+2];
  assign wr_cur = entries_q[wr_idx];
  assign wr_hit = valid[wr_idx] && (wr_cur.tag == wr_tag);

  always_comb begin
    wr_en  = 1'b0;
    alloc  = 1'b0;
    wr_ent = wr_cur;
    if (bus.update_en && !bus.clear) begin
      if (wr_hit) begin
        wr_en = 1'b1;
        if (bus.update_taken) begin
          wr_ent.ctr    = (wr_cur.ctr == 2'b11) ? 2'b11 : wr_cur.ctr + 2'd1;
          wr_ent.target = bus.update_target;
        end else begin
          wr_ent.ctr = (wr_cur.ctr == 2'b00) ? 2'b00 : wr_cur.ctr - 2'd1;
        end
      end else if (bus.update_taken) begin
        // Taken miss replaces whatever occupied the slot, starting at weak taken.
        wr_en         = 1'b1;
        alloc         = 1'b1;
        wr_ent.tag    = wr_tag;
        wr_ent.target = bus.update_target;
        wr_ent.ctr    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (bus.clear) begin
      valid <= '0;
    end else if (alloc) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      entries_q[wr_idx] <= wr_ent;
    end
  end
endmodule

// File: tb/tb_btb.sv
// Directed scoreboard bench for btb: each driven cycle queues its expected lookup result,
// and a negedge monitor pops and compares against what the DUT presents.
module tb_btb;
  logic clk;
  logic rst;

  btb_if bus ();

  btb #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic        v;
    logic        t;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   step     = 0;
  logic chk_vld  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (chk_vld) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: got empty scoreboard, required an expectation");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.btb_pc_valid !== e.v || bus.btb_pc_predictTaken !== e.t || bus.btb_target_pc !== e.tgt) begin
          failures++;
          $display("FAIL step%0d pc=%h: got valid=%b taken=%b target=%h, required valid=%b taken=%b target=%h",
                   e.step, e.pc, bus.btb_pc_valid, bus.btb_pc_predictTaken, bus.btb_target_pc,
                   e.v, e.t, e.tgt);
        end
      end
    end
  end

  // One cycle: drive update/clear/lookup, queue expected pre-update lookup result.
  task automatic cyc(input logic ue, input logic [31:0] upc, input logic [31:0] utgt,
                     input logic utk, input logic clr, input logic [31:0] lpc,
                     input logic ev, input logic et, input logic [31:0] etgt);
    exp_t e;
    bus.update_en     = ue;
    bus.update_pc     = upc;
    bus.update_target = utgt;
    bus.update_taken  = utk;
    bus.clear         = clr;
    bus.pc            = lpc;
    step++;
    e.step = step;
    e.pc   = lpc;
    e.v    = ev;
    e.t    = et;
    e.tgt  = etgt;
    sb.push_back(e);
    chk_vld = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] lpc, input logic ev, input logic et, input logic [31:0] etgt);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, lpc, ev, et, etgt);
  endtask

  task automatic upd(input logic [31:0] upc, input logic [31:0] utgt, input logic utk,
                     input logic [31:0] lpc, input logic ev, input logic et, input logic [31:0] etgt);
    cyc(1'b1, upc, utgt, utk, 1'b0, lpc, ev, et, etgt);
  endtask

  initial begin
    rst               = 1'b0;
    bus.pc            = 32'h40;
    bus.update_en     = 1'b0;
    bus.update_pc     = 32'h0;
    bus.update_target = 32'h0;
    bus.update_taken  = 1'b0;
    bus.clear         = 1'b0;
    @(posedge clk);
    #1;

    // Reset: outputs zero, and an update during reset is ignored.
    upd(32'h40, 32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    look(32'h40, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    look(32'h40, 1'b0, 1'b0, 32'h0);

    // Allocate, then counter walk 10->11->11->10->01->00->00.
    upd(32'h40, 32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    upd(32'h40, 32'h100, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 32'h100, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 32'h999, 1'b0, 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 32'h999, 1'b0, 32'h40, 1'b1, 1'b1, 32'h100);
    look(32'h43, 1'b1, 1'b0, 32'h100);
    upd(32'h40, 32'h999, 1'b0, 32'h40, 1'b1, 1'b0, 32'h100);
    upd(32'h40, 32'h999, 1'b0, 32'h40, 1'b1, 1'b0, 32'h100);
    // Taken hit from 00 -> 01 rewrites target without flipping prediction.
    upd(32'h40, 32'h140, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100);
    look(32'h40, 1'b1, 1'b0, 32'h140);
    upd(32'h40, 32'h140, 1'b1, 32'h40, 1'b1, 1'b0, 32'h140);

    // Same-cycle hazard from counter 10.
    upd(32'h40, 32'h140, 1'b0, 32'h40, 1'b1, 1'b1, 32'h140);
    look(32'h40, 1'b1, 1'b0, 32'h140);

    // Alias replacement at index 0, then not-taken miss leaves table unchanged.
    upd(32'h80, 32'h200, 1'b1, 32'h40, 1'b1, 1'b0, 32'h140);
    look(32'h40, 1'b0, 1'b0, 32'h0);
    look(32'h80, 1'b1, 1'b1, 32'h200);
    upd(32'h40, 32'h300, 1'b0, 32'h80, 1'b1, 1'b1, 32'h200);
    look(32'h80, 1'b1, 1'b1, 32'h200);
    look(32'h40, 1'b0, 1'b0, 32'h0);

    // Second index, independent of index 0.
    upd(32'h44, 32'h500, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
    look(32'h44, 1'b1, 1'b1, 32'h500);

    // Clear wins over a simultaneous taken update.
    cyc(1'b1, 32'hC0, 32'h600, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h200);
    look(32'hC0, 1'b0, 1'b0, 32'h0);
    look(32'h40, 1'b0, 1'b0, 32'h0);
    look(32'h80, 1'b0, 1'b0, 32'h0);
    look(32'h44, 1'b0, 1'b0, 32'h0);

    // Re-allocate, then asynchronous reset mid-operation discards it.
    upd(32'h80, 32'h200, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    look(32'h80, 1'b1, 1'b1, 32'h200);
    rst = 1'b0;
    look(32'h80, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    upd(32'h80, 32'h700, 1'b0, 32'h80, 1'b0, 1'b0, 32'h0);
    look(32'h80, 1'b0, 1'b0, 32'h0);
    upd(32'h80, 32'h700, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    look(32'h80, 1'b1, 1'b1, 32'h700);

    chk_vld = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d leftover expectations, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
